// File: rtl/idc_param.sv
// Parametrised image display controller: loads a MAP_DIM^2 signed image plus OP_NUM opcodes,
// applies them to a 2x2 cursor window, then streams a zoomed view over valid/ready.
module idc_param #(
    parameter int DW      = 7,
    parameter int MAP_DIM = 8,
    parameter int OP_NUM  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [3:0]    op,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);
    localparam int AW = $clog2(MAP_DIM);
    localparam int IW = 2 * AW;
    localparam int BW = 2 * (AW - 1);
    localparam int OW = $clog2(OP_NUM + 1);
    localparam logic [AW-1:0] CTR  = AW'(MAP_DIM / 2 - 1);
    localparam logic [AW-1:0] CMAX = AW'(MAP_DIM - 2);

    typedef logic signed [DW-1:0] pix_t;
    typedef logic signed [DW+1:0] wide_t;
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, EMIT} state_t;

    localparam wide_t TWO  = wide_t'(2);
    localparam wide_t FOUR = wide_t'(4);

    state_t         state, state_nx;
    pix_t           map [MAP_DIM*MAP_DIM];
    logic [3:0]     ops [OP_NUM];
    logic [IW-1:0]  ld_cnt;
    logic [OW-1:0]  op_idx;
    logic [AW-1:0]  row, col, row1, col1;
    logic [BW-1:0]  beat, beat_sel;

    logic [IW-1:0]  i_tl, i_tr, i_bl, i_br, rd_idx;
    pix_t           tl, tr, bl, br, mx, mn, mx01, mx23, mn01, mn23, fill;
    wide_t          sum, mid2, mid_w, avg_w;
    logic [3:0]     cur_op;
    logic [AW-2:0]  bi, bj;
    logic [AW-1:0]  rd_row, rd_col;
    logic           zoom_out;

    function automatic wide_t sx(input pix_t p);
        return {{2{p[DW-1]}}, p};
    endfunction

    always_comb begin
        row1 = row + AW'(1);
        col1 = col + AW'(1);
        i_tl = {row, col};
        i_tr = {row, col1};
        i_bl = {row1, col};
        i_br = {row1, col1};
        tl = map[i_tl];
        tr = map[i_tr];
        bl = map[i_bl];
        br = map[i_br];
        mx01 = (tl > tr) ? tl : tr;
        mx23 = (bl > br) ? bl : br;
        mx   = (mx01 > mx23) ? mx01 : mx23;
        mn01 = (tl < tr) ? tl : tr;
        mn23 = (bl < br) ? bl : br;
        mn   = (mn01 < mn23) ? mn01 : mn23;
        sum  = sx(tl) + sx(tr) + sx(bl) + sx(br);
        // Middle two of the sorted four = total minus the extremes.
        mid2  = sum - sx(mx) - sx(mn);
        mid_w = mid2 / TWO;
        avg_w = sum / FOUR;
        cur_op = ops[op_idx];
        case (cur_op)
            4'd0:    fill = mid_w[DW-1:0];
            4'd1:    fill = avg_w[DW-1:0];
            4'd9:    fill = mx;
            default: fill = mn;
        endcase
    end

    always_comb begin
        beat_sel = out_valid ? beat + BW'(1) : beat;
        bi = beat_sel[BW-1:AW-1];
        bj = beat_sel[AW-2:0];
        zoom_out = row[AW-1] | col[AW-1];
        rd_row = zoom_out ? {bi, 1'b0} : row1 + AW'(bi);
        rd_col = zoom_out ? {bj, 1'b0} : col1 + AW'(bj);
        rd_idx = {rd_row, rd_col};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = LOAD;
            LOAD: if (!in_valid) state_nx = EXEC;
            EXEC: if (op_idx == OW'(OP_NUM - 1)) state_nx = EMIT;
            EMIT: if (out_valid && out_ready && beat == '1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MAP_DIM * MAP_DIM; k++) map[k] <= '0;
            for (int unsigned k = 0; k < OP_NUM; k++) ops[k] <= '0;
            ld_cnt    <= '0;
            op_idx    <= '0;
            row       <= CTR;
            col       <= CTR;
            beat      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row    <= CTR;
                    col    <= CTR;
                    beat   <= '0;
                    op_idx <= '0;
                    if (in_valid) begin
                        map[0] <= in_data;
                        ops[0] <= op;
                        ld_cnt <= IW'(1);
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        map[ld_cnt] <= in_data;
                        if (int'(ld_cnt) < OP_NUM) ops[OW'(ld_cnt)] <= op;
                        ld_cnt <= ld_cnt + IW'(1);
                    end
                end
                EXEC: begin
                    op_idx <= op_idx + OW'(1);
                    case (cur_op)
                        4'd0, 4'd1, 4'd9, 4'd10: begin
                            map[i_tl] <= fill;
                            map[i_tr] <= fill;
                            map[i_bl] <= fill;
                            map[i_br] <= fill;
                        end
                        4'd2: begin
                            map[i_tl] <= tr;
                            map[i_tr] <= br;
                            map[i_br] <= bl;
                            map[i_bl] <= tl;
                        end
                        4'd3: begin
                            map[i_tl] <= bl;
                            map[i_bl] <= br;
                            map[i_br] <= tr;
                            map[i_tr] <= tl;
                        end
                        4'd4: begin
                            map[i_tl] <= -tl;
                            map[i_tr] <= -tr;
                            map[i_bl] <= -bl;
                            map[i_br] <= -br;
                        end
                        4'd5: if (row != '0) row <= row - AW'(1);
                        4'd6: if (col != '0) col <= col - AW'(1);
                        4'd7: if (row < CMAX) row <= row1;
                        4'd8: if (col < CMAX) col <= col1;
                        default: ;
                    endcase
                end
                EMIT: begin
                    // First EMIT cycle only primes the output register; later updates follow transfers.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= map[rd_idx];
                    end else if (out_ready) begin
                        if (beat == '1) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                        end else begin
                            beat     <= beat + BW'(1);
                            out_data <= map[rd_idx];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/idc_param.md
Name: idc_param

Overview:
- Parametrised image display controller, successor to the fixed 8x8 IDC.
- Loads a MAP_DIM x MAP_DIM signed image and OP_NUM opcodes, then applies the opcodes one per cycle to a 2x2 cursor window.
- Streams out a (MAP_DIM/2)^2 zoomed view over a valid/ready output handshake.
- Adds max/min window ops and output back-pressure, which the fixed block lacks.

Parameters:
- DW, 7, signed pixel width in bits.
- MAP_DIM, 8, image side length; power of two, >=4.
- OP_NUM, 15, opcodes captured per pattern; >=1.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  high for exactly MAP_DIM*MAP_DIM consecutive cycles per pattern.
- in_data  in  DW  signed pixel, row-major, row 0 column 0 first.
- op  in  4  opcode; sampled during the first OP_NUM in_valid cycles only.
- out_ready  in  1  sink ready; a beat transfers when out_valid && out_ready.
- out_valid  out  1  output beat valid.
- out_data  out  DW  signed output pixel.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, map and op store cleared, FSM to IDLE. Reset mid-operation abandons the pattern; no further beats appear.
- FSM: IDLE -> LOAD (on in_valid) -> EXEC (in_valid falls) -> EMIT (after OP_NUM ops) -> IDLE (after last beat transfers).
- IDLE entry: cursor (row, col) = (MAP_DIM/2-1, MAP_DIM/2-1).
- EXEC timing: exactly one opcode per cycle, in capture order. Window is rows {row, row+1} x cols {col, col+1}; TL=(row,col), TR=(row,col+1), BL=(row+1,col), BR=(row+1,col+1).
- Opcodes:
  - 0 midpoint: sort the 4 pixels; result=(2nd+3rd)/2, truncated toward zero; written to all 4.
  - 1 average: result=sum/4, truncated toward zero; sum held in DW+2 bits; written to all 4.
  - 2 counter-clockwise: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 3 clockwise: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
  - 4 flip: each pixel <= two's-complement negation mod 2^DW; the most-negative value maps to itself.
  - 5 up: row-1, clamped at 0. 6 left: col-1, clamped at 0. 7 down: row+1, clamped at MAP_DIM-2. 8 right: col+1, clamped at MAP_DIM-2.
  - 9 max: signed maximum of the 4, written to all 4. 10 min: signed minimum, written to all 4.
  - 11-15: no-op; still consumes one cycle.
- Zoom selection: uses the final cursor.
  - Zoom-out if row>=MAP_DIM/2 or col>=MAP_DIM/2: emit pixels (2i, 2j).
  - Zoom-in otherwise: emit pixels (row+1+i, col+1+j).
  - In both cases i, j = 0..MAP_DIM/2-1, row-major, (MAP_DIM/2)^2 beats.
- EMIT handshake:
  - out_valid rises within OP_NUM+4 cycles after in_valid falls.
  - out_data is registered and stays stable while out_valid && !out_ready.
  - The next beat may follow a transfer with no bubble.
  - out_valid drops the cycle after the final transfer; out_data returns to 0 whenever out_valid=0.
- in_valid asserted outside IDLE is ignored.

Test Plan:
- Cursor (3,3), op0 on window 5,-3,6,-7 -> all four become (-3+5)/2=1. Final cursor (3,3) so zoom-in: first beat is pixel (4,4).
- op1 on window -1,-2,-3,-4 (sum -10) -> all four -2. op9 on 5,-3,6,-7 -> all four 6. op10 -> all four -7.
- Pixel -64 with op4 (DW=7) -> stays -64. Pixel 63 -> -63.
- 10 consecutive op5 then op6 -> cursor clamps at (0,2), no wrap. 10 consecutive op7 -> row 6, zoom-out: beats are (0,0),(0,2)..(6,6), 16 beats.
- out_ready toggled 1,0,0,1 during EMIT -> each beat held while stalled. Exactly 16 transfers in order, then out_valid=0.
- rst_n pulsed low mid-EXEC -> out_valid=0 immediately. Next full pattern produces correct output. Repeat with MAP_DIM=16, OP_NUM=20: 64 beats.
